// File: rtl/matmul_operand_loader.sv
// Register/operand-buffer stage between the matmul APB slave and the matmul core.
// Optional A/B buffer readback is enabled by defining MATMUL_LOADER_READBACK_EN.
module matmul_operand_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int ROW_W     = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [BUS_WIDTH-1:0]  wdata_i,
  input  logic [MAX_DIM-1:0]    strb_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [BUS_WIDTH-1:0]  rdata_o,
  output logic                  op_valid_o,
  input  logic                  op_ready_i,
  output logic                  op_sel_o,
  output logic [ROW_W-1:0]      op_row_o,
  output logic [BUS_WIDTH-1:0]  op_data_o,
  input  logic                  core_done_i,
  output logic                  busy_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_A    = 2'd1,
    S_LOAD_B    = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;
  logic                  op_valid_q, op_valid_d;
  logic                  op_sel_q, op_sel_d;
  logic [ROW_W-1:0]      op_row_q, op_row_d;
  logic [BUS_WIDTH-1:0]  op_data_q, op_data_d;
  logic                  done_q, done_d;
  logic                  err_seen_q, err_seen_d;
  logic [BUS_WIDTH-1:0]  a_q [MAX_DIM];
  logic [BUS_WIDTH-1:0]  a_d [MAX_DIM];
  logic [BUS_WIDTH-1:0]  b_q [MAX_DIM];
  logic [BUS_WIDTH-1:0]  b_d [MAX_DIM];

  logic [3:0]            region;
  logic [3:0]            row_idx;
  logic                  hi_bad;
  logic                  row_bad;
  logic                  busy;
  logic [ROW_W-1:0]      buf_row;
  logic [ROW_W-1:0]      nxt_row;
  logic                  last_row;

  assign region   = addr_i[7:4];
  assign row_idx  = addr_i[3:0];
  assign hi_bad   = |addr_i[ADDR_WIDTH-1:8];
  assign row_bad  = ({1'b0, row_idx} >= 5'(MAX_DIM));
  assign buf_row  = row_idx[ROW_W-1:0];
  assign busy     = (state_q != S_IDLE);
  assign nxt_row  = op_row_q + ROW_W'(1);
  assign last_row = (op_row_q == ROW_W'(MAX_DIM - 1));

  // Core handshake: a row transfers on every rising edge where op_valid_o and
  // op_ready_i are both high; while valid is high and ready is low, sel/row/data hold.
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    op_valid_d = op_valid_q;
    op_sel_d   = op_sel_q;
    op_row_d   = op_row_q;
    op_data_d  = op_data_q;
    done_d     = done_q;
    err_seen_d = err_seen_q;
    a_d        = a_q;
    b_d        = b_q;

    unique case (state_q)
      S_LOAD_A: begin
        if (op_ready_i) begin
          if (last_row) begin
            state_d   = S_LOAD_B;
            op_sel_d  = 1'b1;
            op_row_d  = '0;
            op_data_d = b_q[0];
          end else begin
            op_row_d  = nxt_row;
            op_data_d = a_q[nxt_row];
          end
        end
      end
      S_LOAD_B: begin
        if (op_ready_i) begin
          if (last_row) begin
            state_d    = S_WAIT_DONE;
            op_valid_d = 1'b0;
            op_sel_d   = 1'b0;
            op_row_d   = '0;
            op_data_d  = '0;
          end else begin
            op_row_d  = nxt_row;
            op_data_d = b_q[nxt_row];
          end
        end
      end
      S_WAIT_DONE: begin
        if (core_done_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase

    // Buffer writes, START and CLEAR are all refused while busy, so the
    // buffers cannot change under an active stream.
    if (wr_en_i || rd_en_i) begin
      ack_d = 1'b1;
      if ((wr_en_i && rd_en_i) || hi_bad) begin
        err_d = 1'b1;
      end else begin
        case (region)
          4'h0: begin
            if (wr_en_i) begin
              if (busy || (wdata_i[0] && wdata_i[1])) begin
                err_d = 1'b1;
              end else if (wdata_i[0]) begin
                state_d    = S_LOAD_A;
                op_valid_d = 1'b1;
                op_sel_d   = 1'b0;
                op_row_d   = '0;
                op_data_d  = a_q[0];
                done_d     = 1'b0;
                err_seen_d = 1'b0;
              end else if (wdata_i[1]) begin
                for (int i = 0; i < MAX_DIM; i++) begin
                  a_d[i] = '0;
                  b_d[i] = '0;
                end
              end
            end
          end
          4'h1, 4'h2: begin
            if (row_bad) begin
              err_d = 1'b1;
            end else if (rd_en_i) begin
`ifdef MATMUL_LOADER_READBACK_EN
              rdata_d = (region == 4'h1) ? a_q[buf_row] : b_q[buf_row];
`else
              err_d = 1'b1;
`endif
            end else if (busy) begin
              err_d = 1'b1;
            end else begin
              for (int j = 0; j < MAX_DIM; j++) begin
                if (strb_i[j]) begin
                  if (region == 4'h1) begin
                    a_d[buf_row][j*DATA_WIDTH +: DATA_WIDTH] = wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
                  end else begin
                    b_d[buf_row][j*DATA_WIDTH +: DATA_WIDTH] = wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
                  end
                end
              end
            end
          end
          4'h3: begin
            if (wr_en_i) begin
              err_d = 1'b1;
            end else begin
              rdata_d = BUS_WIDTH'({err_seen_q, done_q, busy});
            end
          end
          default: err_d = 1'b1;
        endcase
      end
      if (err_d) begin
        err_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      op_valid_q <= 1'b0;
      op_sel_q   <= 1'b0;
      op_row_q   <= '0;
      op_data_q  <= '0;
      done_q     <= 1'b0;
      err_seen_q <= 1'b0;
      for (int i = 0; i < MAX_DIM; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      op_valid_q <= op_valid_d;
      op_sel_q   <= op_sel_d;
      op_row_q   <= op_row_d;
      op_data_q  <= op_data_d;
      done_q     <= done_d;
      err_seen_q <= err_seen_d;
      for (int i = 0; i < MAX_DIM; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
      end
    end
  end

  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign op_valid_o  = op_valid_q;
  assign op_sel_o    = op_sel_q;
  assign op_row_o    = op_row_q;
  assign op_data_o   = op_data_q;
  assign busy_o      = busy;
  assign dbg_state_o = state_q;

endmodule
